// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The master side is the sequencer. The slave side is the datapath, or a bench standing in for it.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer. It is a Moore FSM, except for the mem_ready qualifiers and the two error pulses.
// Memory states stall on mem_ready, and a stuck memory is abandoned after WAIT_TIMEOUT stalled cycles.
module multicycle_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [7:0] TMO     = 8'(WAIT_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       in_mem, timeout;

    // The controller only enables the conditional PC load. The datapath gates it with zero.
    logic unused_zero;
    assign unused_zero = bus.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        in_mem            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        bus.mem_timeout   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                in_mem        = 1'b1;
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                in_mem       = 1'b1;
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                in_mem        = 1'b1;
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A ready memory beats the timeout on the same cycle.
        timeout = in_mem && !bus.mem_ready && (wcnt_q == TMO);
        if (timeout) begin
            bus.mem_timeout = 1'b1;
            state_d         = S_FETCH;
        end

        if (timeout || (state_d != state_q)) wcnt_d = '0;
        else if (in_mem && !bus.mem_ready)   wcnt_d = wcnt_q + 8'd1;
        else                                 wcnt_d = wcnt_q;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed check of multicycle_ctrl against a table-driven instruction model.
// The model expands each instruction into its step list. Stall counts decide whether a memory step completes or aborts.
module tb_multicycle_ctrl;
    localparam int TO = 4;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_JUMP = 10, P_ADDIEX = 11, P_ADDIWB = 12;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal_op, mem_timeout;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.WAIT_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic ctl_t expect_ph(int p, bit rdy, bit ill, bit tmo);
        ctl_t c = '0;
        case (p)
            P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE: c.alu_src_b = 2'b11;
            P_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_MEMRD:  begin c.mem_read = 1; c.i_or_d = 1; end
            P_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            P_MEMWR:  begin c.mem_write = 1; c.i_or_d = 1; end
            P_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            P_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
            P_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1; end
            P_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            P_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            P_ADDIWB: c.reg_write = 1;
            default:  c = '0;
        endcase
        c.illegal_op  = ill;
        c.mem_timeout = tmo;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.pc_write = bus.pc_write;     c.pc_write_cond = bus.pc_write_cond;
        c.i_or_d = bus.i_or_d;         c.mem_read = bus.mem_read;
        c.mem_write = bus.mem_write;   c.ir_write = bus.ir_write;
        c.mem_to_reg = bus.mem_to_reg; c.reg_dst = bus.reg_dst;
        c.reg_write = bus.reg_write;   c.alu_src_a = bus.alu_src_a;
        c.alu_src_b = bus.alu_src_b;   c.alu_op = bus.alu_op;
        c.pc_source = bus.pc_source;   c.illegal_op = bus.illegal_op;
        c.mem_timeout = bus.mem_timeout;
        return c;
    endfunction

    task automatic check(ctl_t exp, string tag);
        ctl_t obs;
        obs = observe();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1. Drives one cycle, checks mid-cycle, and leaves at the next posedge+1.
    task automatic step(int p, bit rdy, logic [5:0] opc, bit ill, bit tmo, string tag);
        bus.mem_ready = rdy;
        bus.opcode    = opc;
        bus.zero      = 1'($urandom);
        #2;
        check(expect_ph(p, rdy, ill, tmo), tag);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(int p, int nstall, string tag, output bit aborted);
        aborted = 0;
        for (int k = 0; k <= TO; k++) begin
            bit r, t;
            r = (k == nstall);
            t = !r && (k == TO);
            step(p, r, 6'($urandom), 0, t, tag);
            if (r) return;
            if (t) begin aborted = 1; return; end
        end
    endtask

    task automatic run_instr(logic [5:0] opc, int fst, int mst, string tag);
        bit ab, ill;
        mem_phase(P_FETCH, fst, {tag, "/fetch"}, ab);
        if (ab) return;
        ill = !(opc inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
        step(P_DECODE, 1'($urandom), opc, ill, 0, {tag, "/decode"});
        case (opc)
            6'h23: begin
                step(P_MEMADR, 1'($urandom), opc, 0, 0, {tag, "/memadr"});
                mem_phase(P_MEMRD, mst, {tag, "/memrd"}, ab);
                if (!ab) step(P_MEMWB, 1'($urandom), 6'($urandom), 0, 0, {tag, "/memwb"});
            end
            6'h2B: begin
                step(P_MEMADR, 1'($urandom), opc, 0, 0, {tag, "/memadr"});
                mem_phase(P_MEMWR, mst, {tag, "/memwr"}, ab);
            end
            6'h00: begin
                step(P_EXEC, 1'($urandom), 6'($urandom), 0, 0, {tag, "/exec"});
                step(P_ALUWB, 1'($urandom), 6'($urandom), 0, 0, {tag, "/aluwb"});
            end
            6'h04: step(P_BRANCH, 1'($urandom), 6'($urandom), 0, 0, {tag, "/branch"});
            6'h02: step(P_JUMP, 1'($urandom), 6'($urandom), 0, 0, {tag, "/jump"});
            6'h08: begin
                step(P_ADDIEX, 1'($urandom), 6'($urandom), 0, 0, {tag, "/addiex"});
                step(P_ADDIWB, 1'($urandom), 6'($urandom), 0, 0, {tag, "/addiwb"});
            end
            default: ;
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
        bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        step(P_IDLE, 1, 6'h23, 0, 0, "reset_hold");
        rst_n = 1'b1;
        step(P_IDLE, 1, 6'h23, 0, 0, "idle_after_release");

        run_instr(6'h23, 0, 0, "lw");
        bus.zero = 1'b1;
        run_instr(6'h04, 0, 0, "beq_z1");
        run_instr(6'h04, 0, 0, "beq_z0");
        run_instr(6'h2B, 0, 3, "sw_stall3");
        run_instr(6'h23, 99, 0, "fetch_timeout");
        run_instr(6'h3F, 0, 0, "illegal");
        run_instr(6'h00, 2, 0, "rtype");
        run_instr(6'h08, 0, 0, "addi");
        run_instr(6'h02, 4, 0, "j_stall4");
        run_instr(6'h23, 0, 99, "lw_rd_timeout");
        run_instr(6'h2B, 1, 99, "sw_wr_timeout");

        // Asynchronous reset in the middle of a load's memory read
        step(P_FETCH, 1, 6'h00, 0, 0, "rst_mid/fetch");
        step(P_DECODE, 0, 6'h23, 0, 0, "rst_mid/decode");
        step(P_MEMADR, 0, 6'h23, 0, 0, "rst_mid/memadr");
        bus.mem_ready = 1'b0;
        #2;
        check(expect_ph(P_MEMRD, 0, 0, 0), "rst_mid/memrd");
        rst_n = 1'b0;
        #1;
        check(expect_ph(P_IDLE, 0, 0, 0), "rst_mid/async_zero");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(P_IDLE, 1, 6'h23, 0, 0, "rst_mid/idle");

        for (int i = 0; i < 60; i++) begin
            int fst, mst;
            fst = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 2);
            mst = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, TO);
            run_instr(ops[$urandom_range(0, 7)], fst, mst, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
